// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory behind the core's load/store port: post-reset clear sweep,
// address legality checking, sticky first-fault capture and saturating access counters.
module data_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          DEPTH     = 256,
    parameter int          AW        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    input  logic        clr_fault,
    output logic [31:0] dReadData,
    output logic        ready,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] fault_addr,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

    logic [31:0]   mem [DEPTH];
    state_t        state;
    logic [AW-1:0] clr_idx;

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          mis, oor, any_strb, bad_strb, illegal, ld_ok, st_ok;
    logic [1:0]    code;

    // Addresses below the base wrap to large offsets and so fall out of range.
    assign off      = dAddress - BASE_ADDR;
    assign idx      = off[AW+1:2];
    assign mis      = |off[1:0];
    assign oor      = off >= SPAN;
    assign any_strb = MemRead | MemWrite;
    assign bad_strb = (MemRead & MemWrite) | (any_strb & ~ready);
    assign illegal  = any_strb & (bad_strb | mis | oor);
    assign ld_ok    = MemRead & ~illegal;
    assign st_ok    = MemWrite & ~illegal;

    always_comb begin
        code = 2'b10;
        if (bad_strb)
            code = 2'b11;
        else if (mis)
            code = 2'b01;
    end

    // The array has no reset; rst only blocks writes so a store at the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                mem[clr_idx] <= '0;
            else if (st_ok)
                mem[idx] <= dWriteData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            clr_idx <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dReadData <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            if (ld_ok) begin
                dReadData <= mem[idx];
                if (rd_count != 16'hFFFF)
                    rd_count <= rd_count + 16'd1;
            end
            if (st_ok && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
        end
    end

    // A fault arriving with clr_fault wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_code <= '0;
            fault_addr <= '0;
        end else if (illegal && (!fault || clr_fault)) begin
            fault      <= 1'b1;
            fault_code <= code;
            fault_addr <= dAddress;
        end else if (clr_fault) begin
            fault      <= 1'b0;
            fault_code <= '0;
            fault_addr <= '0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: reset/sweep timing, a table of single-cycle accesses,
// load-count saturation and strobes issued during the clear sweep.
module tb_data_mem_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0, clr_fault = 1'b0;
    logic [31:0] dAddress = '0, dWriteData = '0;
    logic [31:0] dReadData, fault_addr;
    logic        ready, fault;
    logic [1:0]  fault_code;
    logic [15:0] rd_count, wr_count;

    int checks = 0;
    int failures = 0;

    data_mem_ctrl #(.BASE_ADDR(32'h10010000), .DEPTH(DEPTH), .AW(8)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .dAddress(dAddress), .dWriteData(dWriteData), .clr_fault(clr_fault),
        .dReadData(dReadData), .ready(ready), .fault(fault), .fault_code(fault_code),
        .fault_addr(fault_addr), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, clr;
        logic [31:0] addr, wdata;
        logic [31:0] rdata;
        logic        f;
        logic [1:0]  code;
        logic [31:0] faddr;
        logic [15:0] rdc, wrc;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic rd, wr, clr, input logic [31:0] addr, wdata, rdata,
                                input logic f, input logic [1:0] code, input logic [31:0] faddr,
                                input logic [15:0] rdc, wrc);
        vec_t v;
        v.rd = rd; v.wr = wr; v.clr = clr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.f = f; v.code = code; v.faddr = faddr; v.rdc = rdc; v.wrc = wrc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic c,
                        input logic [31:0] a, input logic [31:0] d);
        MemRead = r; MemWrite = w; clr_fault = c; dAddress = a; dWriteData = d;
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; clr_fault = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < DEPTH + 16) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    int n;

    initial begin
        // row: rd wr clr addr wdata | rdata fault code faddr rd_count wr_count
        tbl[0]  = mk(1,0,0, 32'h10010014, 0,            32'h0,        0, 2'b00, 32'h0,        1, 0);
        tbl[1]  = mk(1,0,0, 32'h100103FC, 0,            32'h0,        0, 2'b00, 32'h0,        2, 0);
        tbl[2]  = mk(0,1,0, 32'h10010004, 32'hDEADBEEF, 32'h0,        0, 2'b00, 32'h0,        2, 1);
        tbl[3]  = mk(1,0,0, 32'h10010004, 0,            32'hDEADBEEF, 0, 2'b00, 32'h0,        3, 1);
        tbl[4]  = mk(1,0,0, 32'h10010002, 0,            32'hDEADBEEF, 1, 2'b01, 32'h10010002, 3, 1);
        tbl[5]  = mk(0,0,1, 32'h0,        0,            32'hDEADBEEF, 0, 2'b00, 32'h0,        3, 1);
        tbl[6]  = mk(0,1,0, 32'h10010400, 32'h11111111, 32'hDEADBEEF, 1, 2'b10, 32'h10010400, 3, 1);
        tbl[7]  = mk(0,1,0, 32'h1000FFFC, 32'h22222222, 32'hDEADBEEF, 1, 2'b10, 32'h10010400, 3, 1);
        tbl[8]  = mk(0,0,1, 32'h0,        0,            32'hDEADBEEF, 0, 2'b00, 32'h0,        3, 1);
        tbl[9]  = mk(1,0,0, 32'h10010000, 0,            32'h0,        0, 2'b00, 32'h0,        4, 1);
        tbl[10] = mk(1,0,0, 32'h100103FC, 0,            32'h0,        0, 2'b00, 32'h0,        5, 1);
        tbl[11] = mk(1,1,0, 32'h10010008, 32'h55555555, 32'h0,        1, 2'b11, 32'h10010008, 5, 1);
        tbl[12] = mk(1,0,1, 32'h10010403, 0,            32'h0,        1, 2'b01, 32'h10010403, 5, 1);
        tbl[13] = mk(0,0,1, 32'h0,        0,            32'h0,        0, 2'b00, 32'h0,        5, 1);
        tbl[14] = mk(1,0,0, 32'h10010008, 0,            32'h0,        0, 2'b00, 32'h0,        6, 1);
        tbl[15] = mk(0,1,0, 32'h100103FC, 32'hA5A5A5A5, 32'h0,        0, 2'b00, 32'h0,        6, 2);
        tbl[16] = mk(1,0,0, 32'h100103FC, 0,            32'hA5A5A5A5, 0, 2'b00, 32'h0,        7, 2);
        tbl[17] = mk(0,1,0, 32'h10010004, 32'hCAFEF00D, 32'hA5A5A5A5, 0, 2'b00, 32'h0,        7, 3);
        tbl[18] = mk(1,0,0, 32'h10010004, 0,            32'hCAFEF00D, 0, 2'b00, 32'h0,        8, 3);
        tbl[19] = mk(0,0,0, 32'h10010004, 0,            32'hCAFEF00D, 0, 2'b00, 32'h0,        8, 3);
        tbl[20] = mk(1,0,0, 32'h00000010, 0,            32'hCAFEF00D, 1, 2'b10, 32'h00000010, 8, 3);
        tbl[21] = mk(0,0,1, 32'h0,        0,            32'hCAFEF00D, 0, 2'b00, 32'h0,        8, 3);

        // First boot, then leave nonzero data that the next sweep has to clear.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_ready(n);
        chk("boot_sweep_len", n, DEPTH);
        step(0, 1, 0, 32'h10010014, 32'h12345678);
        step(0, 1, 0, 32'h100103FC, 32'h87654321);
        step(1, 0, 0, 32'h10010014, 0);
        chk("pre_reset_load", dReadData, 32'h12345678);

        // Async reset, then a second reset in the middle of the sweep.
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_rdata", dReadData, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_faddr", fault_addr, 0);
        chk("rst_rdc", rd_count, 0);
        chk("rst_wrc", wr_count, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("mid_sweep_ready", ready, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        wait_ready(n);
        chk("restart_sweep_len", n, DEPTH);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].clr, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("v%0d_rdata", i), dReadData, tbl[i].rdata);
            chk($sformatf("v%0d_fault", i), fault, tbl[i].f);
            chk($sformatf("v%0d_code", i), fault_code, tbl[i].code);
            chk($sformatf("v%0d_faddr", i), fault_addr, tbl[i].faddr);
            chk($sformatf("v%0d_rdc", i), rd_count, tbl[i].rdc);
            chk($sformatf("v%0d_wrc", i), wr_count, tbl[i].wrc);
        end

        // Back-to-back loads until rd_count pins at its ceiling.
        MemRead = 1'b1; dAddress = 32'h10010004;
        repeat (65540) @(posedge clk);
        #1 MemRead = 1'b0;
        chk("sat_rdc", rd_count, 32'h0000FFFF);
        chk("sat_fault", fault, 0);
        chk("sat_wrc", wr_count, 3);
        chk("sat_rdata", dReadData, 32'hCAFEF00D);
        step(1, 0, 0, 32'h10010004, 0);
        chk("sat_hold", rd_count, 32'h0000FFFF);

        // A store during the sweep is faulted and dropped; sweep length is unaffected.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        step(0, 1, 0, 32'h10010004, 32'hBAADF00D);
        wait_ready(n);
        chk("init_strobe_sweep_len", n + 4, DEPTH);
        chk("init_strobe_fault", fault, 1);
        chk("init_strobe_code", fault_code, 2'b11);
        chk("init_strobe_faddr", fault_addr, 32'h10010004);
        chk("init_strobe_wrc", wr_count, 0);
        step(1, 0, 0, 32'h10010004, 0);
        chk("init_strobe_dropped", dReadData, 0);
        chk("init_strobe_rdc", rd_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
